// File: rtl/inst_mem_if.sv
// Bus bundle between the boot loader / fetch stage (master) and the
// instruction memory (slave): byte-stream load port plus fetch port.
`timescale 1ns/1ps

interface inst_mem_if #(
   parameter int ADDR_WIDTH = 10
);
   // load side
   logic                  load_valid;
   logic [7:0]            load_byte;
   logic                  load_last;
   logic                  load_ready;
   logic                  reload;
   logic                  load_err;
   // fetch side
   logic                  fetch_ready;
   logic                  fetch_req;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic                  inst_valid;
   logic [31:0]           inst;
   logic [ADDR_WIDTH:0]   words_loaded;

   modport master (
      output load_valid, load_byte, load_last, reload, fetch_req, fetch_addr,
      input  load_ready, load_err, fetch_ready, inst_valid, inst, words_loaded
   );

   modport slave (
      input  load_valid, load_byte, load_last, reload, fetch_req, fetch_addr,
      output load_ready, load_err, fetch_ready, inst_valid, inst, words_loaded
   );
endinterface

// File: rtl/inst_mem.sv
// Instruction memory for the fetch stage. The program image arrives as a
// little-endian byte stream (LOAD state); once the last byte is seen the
// block answers word fetches with a fixed one-cycle latency (RUN state).
// Addresses at or beyond the loaded word count return NOP_WORD.
`timescale 1ns/1ps

module inst_mem #(
   parameter int          ADDR_WIDTH = 10,
   parameter int          DEPTH      = 1024,
   parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
   input  logic      clk,
   input  logic      rst,
   inst_mem_if.slave bus
);

   // Index width for the storage array; never wider than ADDR_WIDTH since
   // DEPTH <= 2**ADDR_WIDTH.
   localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              state_r;
   logic                load_ready_r;
   logic                fetch_ready_r;
   logic                load_err_r;
   logic                inst_valid_r;
   logic [31:0]         inst_r;
   // wr_ptr doubles as the loaded-word count: it only advances on a
   // successful write, so it saturates at DEPTH.
   logic [ADDR_WIDTH:0] wr_ptr_r;
   logic [1:0]          byte_idx_r;
   // lanes 0..2 of the word being assembled; lane 3 comes straight from the bus
   logic [23:0]         lane_buf_r;

   // storage is intentionally not reset; words_loaded masks stale entries
   logic [31:0]         mem [DEPTH];

   logic                byte_acc_s;
   logic                word_done_s;
   logic                room_s;
   logic                wr_en_s;
   logic [31:0]         wr_data_s;
   logic                fetch_acc_s;
   logic [ADDR_WIDTH:0] fetch_addr_ext_s;
   logic                addr_hit_s;

   // Handshake qualification, word assembly with zero padding, range compare.
   always_comb begin
      byte_acc_s       = 1'b0;
      word_done_s      = 1'b0;
      room_s           = 1'b0;
      wr_en_s          = 1'b0;
      wr_data_s        = 32'h0000_0000;
      fetch_acc_s      = 1'b0;
      fetch_addr_ext_s = {1'b0, bus.fetch_addr};
      addr_hit_s       = 1'b0;

      // reload wins over a byte or a fetch presented in the same cycle
      if (bus.reload) begin
         byte_acc_s  = 1'b0;
         fetch_acc_s = 1'b0;
      end else begin
         byte_acc_s  = bus.load_valid && load_ready_r;
         fetch_acc_s = bus.fetch_req && fetch_ready_r;
      end

      if (byte_acc_s && (bus.load_last || (byte_idx_r == 2'd3))) begin
         word_done_s = 1'b1;
      end else begin
         word_done_s = 1'b0;
      end

      if (wr_ptr_r < DEPTH_C) begin
         room_s = 1'b1;
      end else begin
         room_s = 1'b0;
      end

      // rst gating keeps the array untouched while reset is held
      if (word_done_s && room_s && rst) begin
         wr_en_s = 1'b1;
      end else begin
         wr_en_s = 1'b0;
      end

      case (byte_idx_r)
         2'd0:    wr_data_s = {24'h00_0000, bus.load_byte};
         2'd1:    wr_data_s = {16'h0000, bus.load_byte, lane_buf_r[7:0]};
         2'd2:    wr_data_s = {8'h00, bus.load_byte, lane_buf_r[15:0]};
         default: wr_data_s = {bus.load_byte, lane_buf_r};
      endcase

      if (fetch_addr_ext_s < wr_ptr_r) begin
         addr_hit_s = 1'b1;
      end else begin
         addr_hit_s = 1'b0;
      end
   end

   // Word-array write port: one assembled word per completed byte group.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem[wr_ptr_r[IDX_W-1:0]] <= wr_data_s;
      end
   end

   // LOAD/RUN state machine with all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= ST_LOAD;
         load_ready_r  <= 1'b1;
         fetch_ready_r <= 1'b0;
         load_err_r    <= 1'b0;
         inst_valid_r  <= 1'b0;
         inst_r        <= NOP_WORD;
         wr_ptr_r      <= '0;
         byte_idx_r    <= 2'd0;
         lane_buf_r    <= 24'h00_0000;
      end else if (bus.reload) begin
         // restart the image; any partial word is dropped
         state_r       <= ST_LOAD;
         load_ready_r  <= 1'b1;
         fetch_ready_r <= 1'b0;
         load_err_r    <= 1'b0;
         inst_valid_r  <= 1'b0;
         wr_ptr_r      <= '0;
         byte_idx_r    <= 2'd0;
      end else begin
         case (state_r)
            ST_LOAD: begin
               inst_valid_r <= 1'b0;
               if (byte_acc_s) begin
                  case (byte_idx_r)
                     2'd0:    lane_buf_r[7:0]   <= bus.load_byte;
                     2'd1:    lane_buf_r[15:8]  <= bus.load_byte;
                     2'd2:    lane_buf_r[23:16] <= bus.load_byte;
                     default: lane_buf_r        <= lane_buf_r;
                  endcase

                  if (word_done_s) begin
                     byte_idx_r <= 2'd0;
                     if (room_s) begin
                        wr_ptr_r <= wr_ptr_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
                     end else begin
                        // image longer than the array: drop and flag
                        load_err_r <= 1'b1;
                     end
                  end else begin
                     byte_idx_r <= byte_idx_r + 2'd1;
                  end

                  if (bus.load_last) begin
                     state_r       <= ST_RUN;
                     load_ready_r  <= 1'b0;
                     fetch_ready_r <= 1'b1;
                  end else begin
                     state_r <= ST_LOAD;
                  end
               end else begin
                  state_r <= ST_LOAD;
               end
            end

            ST_RUN: begin
               inst_valid_r <= fetch_acc_s;
               if (fetch_acc_s) begin
                  if (addr_hit_s) begin
                     inst_r <= mem[bus.fetch_addr[IDX_W-1:0]];
                  end else begin
                     inst_r <= NOP_WORD;
                  end
               end else begin
                  inst_r <= inst_r;
               end
            end

            default: begin
               state_r       <= ST_LOAD;
               load_ready_r  <= 1'b1;
               fetch_ready_r <= 1'b0;
               inst_valid_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.load_ready   = load_ready_r;
   assign bus.fetch_ready  = fetch_ready_r;
   assign bus.load_err     = load_err_r;
   assign bus.inst_valid   = inst_valid_r;
   assign bus.inst         = inst_r;
   assign bus.words_loaded = wr_ptr_r;

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: a full-size instance for the main flows and
// a DEPTH=4 instance for image overflow.
`timescale 1ns/1ps

module tb_inst_mem;

   localparam logic [31:0] NOP = 32'h00000013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   inst_mem_if #(.ADDR_WIDTH(10)) bm ();
   inst_mem_if #(.ADDR_WIDTH(10)) b4 ();

   inst_mem #(.ADDR_WIDTH(10), .DEPTH(1024), .NOP_WORD(NOP)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bm.slave)
   );

   inst_mem #(.ADDR_WIDTH(10), .DEPTH(4), .NOP_WORD(NOP)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (b4.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_status(input bit d4, input string tag, input logic lr, input logic fr,
                               input logic err, input logic [10:0] wl);
      if (d4) begin
         check({tag, ".load_ready"},   32'(b4.load_ready),   32'(lr));
         check({tag, ".fetch_ready"},  32'(b4.fetch_ready),  32'(fr));
         check({tag, ".load_err"},     32'(b4.load_err),     32'(err));
         check({tag, ".words_loaded"}, 32'(b4.words_loaded), 32'(wl));
      end else begin
         check({tag, ".load_ready"},   32'(bm.load_ready),   32'(lr));
         check({tag, ".fetch_ready"},  32'(bm.fetch_ready),  32'(fr));
         check({tag, ".load_err"},     32'(bm.load_err),     32'(err));
         check({tag, ".words_loaded"}, 32'(bm.words_loaded), 32'(wl));
      end
   endtask

   // one cycle on the load port; inputs change 1 ns after the rising edge
   task automatic send(input bit d4, input logic vld, input logic [7:0] b,
                       input logic last, input logic rl);
      if (d4) begin
         b4.load_valid = vld; b4.load_byte = b; b4.load_last = last; b4.reload = rl;
      end else begin
         bm.load_valid = vld; bm.load_byte = b; bm.load_last = last; bm.reload = rl;
      end
      @(posedge clk); #1;
      b4.load_valid = 1'b0; b4.load_last = 1'b0; b4.reload = 1'b0;
      bm.load_valid = 1'b0; bm.load_last = 1'b0; bm.reload = 1'b0;
   endtask

   // single fetch; the response is due right after the accepting edge
   task automatic fetch(input bit d4, input logic [9:0] a, input logic [31:0] exp, input string tag);
      if (d4) begin
         b4.fetch_req = 1'b1; b4.fetch_addr = a;
      end else begin
         bm.fetch_req = 1'b1; bm.fetch_addr = a;
      end
      @(posedge clk); #1;
      b4.fetch_req = 1'b0;
      bm.fetch_req = 1'b0;
      if (d4) begin
         check({tag, ".valid"}, 32'(b4.inst_valid), 32'd1);
         check({tag, ".inst"},  b4.inst, exp);
      end else begin
         check({tag, ".valid"}, 32'(bm.inst_valid), 32'd1);
         check({tag, ".inst"},  bm.inst, exp);
      end
   endtask

   logic [7:0]  img1 [8]  = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hB7, 8'h02, 8'h00, 8'h00};
   logic [7:0]  img2 [6]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hAA};
   logic [9:0]  b2b_a [4] = '{10'd0, 10'd1, 10'd0, 10'd5};
   logic [31:0] b2b_e [4] = '{32'h00100513, 32'h000002B7, 32'h00100513, NOP};

   initial begin
      bm.load_valid = 1'b0; bm.load_byte = 8'h00; bm.load_last = 1'b0; bm.reload = 1'b0;
      bm.fetch_req  = 1'b0; bm.fetch_addr = 10'd0;
      b4.load_valid = 1'b0; b4.load_byte = 8'h00; b4.load_last = 1'b0; b4.reload = 1'b0;
      b4.fetch_req  = 1'b0; b4.fetch_addr = 10'd0;

      // reset values
      #2 rst = 1'b0;
      #1;
      check_status(1'b0, "rst", 1'b1, 1'b0, 1'b0, 11'd0);
      check("rst.inst_valid", 32'(bm.inst_valid), 32'd0);
      check("rst.inst", bm.inst, NOP);
      @(negedge clk) rst = 1'b1;

      // fetch while loading is ignored
      bm.fetch_req = 1'b1; bm.fetch_addr = 10'd0;
      @(posedge clk); #1;
      bm.fetch_req = 1'b0;
      check("load_fetch.valid", 32'(bm.inst_valid), 32'd0);

      // 8-byte image, two words
      for (int i = 0; i < 8; i++) send(1'b0, 1'b1, img1[i], (i == 7), 1'b0);
      check_status(1'b0, "img1", 1'b0, 1'b1, 1'b0, 11'd2);
      fetch(1'b0, 10'd0, 32'h00100513, "img1.f0");
      fetch(1'b0, 10'd1, 32'h000002B7, "img1.f1");

      // back-to-back fetches, then an idle cycle
      bm.fetch_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bm.fetch_addr = b2b_a[i];
         @(posedge clk); #1;
         check($sformatf("b2b%0d.valid", i), 32'(bm.inst_valid), 32'd1);
         check($sformatf("b2b%0d.inst", i), bm.inst, b2b_e[i]);
      end
      bm.fetch_req = 1'b0;
      @(posedge clk); #1;
      check("idle.valid", 32'(bm.inst_valid), 32'd0);
      check("idle.inst", bm.inst, NOP);

      // reload in RUN with a simultaneous fetch: fetch not served
      bm.reload = 1'b1; bm.fetch_req = 1'b1; bm.fetch_addr = 10'd1;
      @(posedge clk); #1;
      bm.reload = 1'b0; bm.fetch_req = 1'b0;
      check("reload.valid", 32'(bm.inst_valid), 32'd0);
      check("reload.inst", bm.inst, NOP);
      check_status(1'b0, "reload", 1'b1, 1'b0, 1'b0, 11'd0);

      // 6-byte image: second word zero-padded in its upper lanes
      for (int i = 0; i < 6; i++) send(1'b0, 1'b1, img2[i], (i == 5), 1'b0);
      check_status(1'b0, "img2", 1'b0, 1'b1, 1'b0, 11'd2);
      fetch(1'b0, 10'd2, NOP,          "img2.f2");
      fetch(1'b0, 10'd0, 32'h44332211, "img2.f0");
      fetch(1'b0, 10'd1, 32'h0000AA55, "img2.f1");

      // DEPTH=4 instance, 20-byte image overflows
      for (int i = 0; i < 20; i++) send(1'b1, 1'b1, 8'(i), (i == 19), 1'b0);
      check_status(1'b1, "ovf", 1'b0, 1'b1, 1'b1, 11'd4);
      fetch(1'b1, 10'd0, 32'h03020100, "ovf.f0");
      fetch(1'b1, 10'd1, 32'h07060504, "ovf.f1");
      fetch(1'b1, 10'd2, 32'h0B0A0908, "ovf.f2");
      fetch(1'b1, 10'd3, 32'h0F0E0D0C, "ovf.f3");
      fetch(1'b1, 10'd4, NOP,          "ovf.f4");

      // reload clears the error; a byte alongside reload is not taken
      send(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      check_status(1'b1, "rl4", 1'b1, 1'b0, 1'b0, 11'd0);
      send(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
      send(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
      send(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
      send(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
      send(1'b1, 1'b1, 8'hD4, 1'b1, 1'b0);
      check_status(1'b1, "img4", 1'b0, 1'b1, 1'b0, 11'd1);
      fetch(1'b1, 10'd0, 32'hD4C3B2A1, "img4.f0");

      // async reset after 3 bytes of a word
      send(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      send(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
      send(1'b0, 1'b1, 8'h88, 1'b0, 1'b0);
      send(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      check_status(1'b0, "arst", 1'b1, 1'b0, 1'b0, 11'd0);
      check("arst.inst_valid", 32'(bm.inst_valid), 32'd0);
      check("arst.inst", bm.inst, NOP);
      @(negedge clk) rst = 1'b1;

      // clean 4-byte image after reset, no leftover lanes
      send(1'b0, 1'b1, 8'hC0, 1'b0, 1'b0);
      send(1'b0, 1'b1, 8'hDE, 1'b0, 1'b0);
      send(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      send(1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
      check_status(1'b0, "img5", 1'b0, 1'b1, 1'b0, 11'd1);
      fetch(1'b0, 10'd0, 32'h0100DEC0, "img5.f0");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/inst_mem.md
Name: inst_mem

Overview:
- Instruction-side responder for the fetch stage. Fetch presents a word-aligned PC and consumes a 32-bit instruction.
- Holds the program image in an internal word array. The image is loaded at boot through a byte-stream load port, for example from a UART loader.
- Serves fetch requests with fixed 1-cycle latency once loading completes.
- Sits between the boot loader and the fetch stage.

Parameters:
- ADDR_WIDTH, 10, word-address width; matches PC_WIDTH.
- DEPTH, 1024, number of 32-bit words; must be <= 2**ADDR_WIDTH.
- NOP_WORD, 32'h00000013, word returned for unloaded or out-of-range addresses.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserts immediately when low, released synchronously to clk).
- load_valid  in  1  load byte present.
- load_byte  in  8  image byte; little-endian within each word.
- load_last  in  1  qualifies the final byte of the image.
- load_ready  out  1  block accepts a load byte this cycle.
- reload  in  1  single-cycle pulse; restarts loading from word 0.
- load_err  out  1  sticky flag: image exceeded DEPTH words.
- fetch_ready  out  1  block serving fetches (RUN state).
- fetch_req  in  1  fetch request this cycle.
- fetch_addr  in  ADDR_WIDTH  word address (PC).
- inst_valid  out  1  inst holds the response to the previous cycle's accepted request.
- inst  out  32  instruction word.
- words_loaded  out  ADDR_WIDTH+1  count of words written in the current image.

Behaviour:
- Reset values:
  - state=LOAD, load_ready=1, fetch_ready=0, inst_valid=0, inst=NOP_WORD, load_err=0, words_loaded=0.
  - Internal byte index=0, wr_ptr=0.
  - Memory array is not cleared; stale contents are masked by words_loaded.
- FSM has two states, LOAD and RUN.
- LOAD state:
  - A byte is accepted when load_valid && load_ready and placed in lane byte_idx: lane 0 -> inst[7:0], lane 3 -> inst[31:24].
  - On the 4th byte, the assembled word is written at wr_ptr; wr_ptr and words_loaded increment and byte_idx returns to 0. The write takes effect the same cycle as the accepted 4th byte.
  - load_last on byte with byte_idx<3: the unfilled upper lanes are zero-padded and the word is written.
  - Any accepted load_last: transition to RUN next cycle; load_ready deasserts on that edge.
  - Overflow: a word write with wr_ptr==DEPTH is dropped. load_err is set and stays set until reset or reload. Bytes keep being accepted until load_last.
  - Fetch requests in LOAD are ignored and inst_valid stays 0.
- RUN state:
  - load_ready=0 and fetch_ready=1.
  - A request is accepted when fetch_req && fetch_ready. On the next cycle inst_valid=1 and inst=mem[fetch_addr], or NOP_WORD if fetch_addr >= words_loaded.
  - With no request, inst_valid=0 and inst holds its last value.
  - Back-to-back requests give one response per cycle at full throughput.
- reload in either state:
  - Next cycle: state=LOAD, wr_ptr=0, byte_idx=0, words_loaded=0, load_err=0, inst_valid=0.
  - A partial word in progress is discarded.
  - A fetch_req in the same cycle as reload is not served.
  - reload takes priority over a simultaneous load byte, which is not accepted.
- Asynchronous reset mid-load or mid-fetch forces every reset value immediately; a pending response is lost.
- Width rules:
  - words_loaded saturates at DEPTH.
  - The range compare is unsigned at ADDR_WIDTH+1 bits.

Test Plan:
- Reset, stream 8 bytes 0x13,0x05,0x10,0x00,0xB7,0x02,0x00,0x00 with load_last on the final byte -> words_loaded=2; RUN next cycle; fetch addr 0 -> inst=0x00100513, addr 1 -> 0x000002B7, each one cycle after its request.
- Image of 6 bytes, last=0xAA at byte 5 -> word1=0x0000AA??, with the upper two lanes zero and the lower lanes from bytes 4-5; words_loaded=2; fetch addr 2 -> NOP_WORD.
- Back-to-back fetch addr 0,1,0,5 in consecutive cycles (2-word image) -> inst_valid high 4 consecutive cycles with the correct words, then NOP_WORD for addr 5; idle cycle after -> inst_valid=0 and inst unchanged.
- DEPTH=4 build, 20-byte image -> load_err=1, words_loaded=4, words 0-3 correct, RUN reached after load_last.
- reload pulse in RUN while fetch_req=1 -> that request is not answered, fetch_ready=0 next cycle, load_err cleared, new 4-byte image fetched correctly at addr 0.
- rst low after 3 bytes of a word -> all outputs at reset values asynchronously; after release, a 4-byte image loads with no residue from the partial bytes.
